// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Serialises every RAM access of the two pipeline requesters (stage-1
// fetcher, read-only; stage-2 executor, read/write) onto one shared path.
// Each access asks the MMU for a logical-to-physical translation, drives
// the block-RAM port for one cycle and returns data with a one-cycle ack.
//
// State table:
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no transaction; pick an eligible requester (round-robin tie)
//   XLATE  | mmu_req high, waiting for mmu_done or the translation timeout
//   ACCESS | one cycle of ram_en at the translated physical address
//   RESP   | RAM data valid on ram_dout; ack/err/rdata registered on exit
//
// Ports:
//   clk, rst                      system clock, async active-low reset
//   fe_req/fe_addr/fe_flush       fetcher read request, address, flush
//   fe_ack/fe_rdata/fe_err        fetcher response (ack is a 1-cycle pulse)
//   ex_req/ex_we/ex_addr/ex_wdata executor request (read or write)
//   ex_ack/ex_rdata/ex_err        executor response (rdata held on writes)
//   mmu_req/mmu_vaddr             translation request (high in XLATE)
//   mmu_done/mmu_err/mmu_paddr    translation result
//   ram_en/ram_we/ram_addr/ram_wdata  block-RAM port
//   ram_dout                      RAM read data, registered by the RAM
//   busy                          high whenever a transaction is in flight
module ram_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int MMU_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              fe_req,
  input  logic [ADDR_W-1:0] fe_addr,
  input  logic              fe_flush,
  output logic              fe_ack,
  output logic [DATA_W-1:0] fe_rdata,
  output logic              fe_err,

  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_ack,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              ex_err,

  output logic              mmu_req,
  output logic [ADDR_W-1:0] mmu_vaddr,
  input  logic              mmu_done,
  input  logic              mmu_err,
  input  logic [ADDR_W-1:0] mmu_paddr,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_dout,

  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XLATE  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic OWN_FE = 1'b0;
  localparam logic OWN_EX = 1'b1;

  // The timeout counter is 4 bits, so the usable limit is 1..16 cycles.
  localparam int TO_CLAMP = (MMU_TIMEOUT < 1)  ? 1 :
                            (MMU_TIMEOUT > 16) ? 16 : MMU_TIMEOUT;
  // cnt holds the number of XLATE cycles already completed; the cycle in
  // which it equals TO_LAST is the last one allowed before erroring out.
  localparam logic [3:0] TO_LAST = 4'(TO_CLAMP - 1);
  localparam logic [3:0] CNT_MAX = 4'hF;

  state_t            state;
  state_t            state_next;

  logic              owner;
  logic              last_grant;
  logic              we_q;
  logic              err_q;
  logic              flushed;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;

  logic              fe_elig;
  logic              ex_elig;
  logic              grant_any;
  logic              grant_owner;
  logic              timeout;
  logic              xlate_ok;
  logic              xlate_fail;
  logic              fe_suppress;

  // --------------------------------------------------------------------
  // Arbitration and translation decode
  // --------------------------------------------------------------------
  always_comb begin
    // A requester whose ack is high this cycle still holds req from the
    // finished access; it must not be granted a second time.
    fe_elig   = fe_req & ~fe_ack & ~fe_flush;
    ex_elig   = ex_req & ~ex_ack;
    grant_any = fe_elig | ex_elig;

    if (fe_elig && ex_elig) begin
      grant_owner = ~last_grant;
    end else if (ex_elig) begin
      grant_owner = OWN_EX;
    end else begin
      grant_owner = OWN_FE;
    end

    timeout     = (cnt == TO_LAST);
    xlate_ok    = mmu_done & ~mmu_err;
    xlate_fail  = (mmu_done & mmu_err) | (~mmu_done & timeout);

    // A flush landing on the RESP edge itself also kills the fetcher ack.
    fe_suppress = flushed | fe_flush;
  end

  // --------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_next = XLATE;
        end
      end
      XLATE: begin
        if (xlate_ok) begin
          state_next = ACCESS;
        end else if (xlate_fail) begin
          state_next = RESP;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // FSM: outputs decoded from state
  // --------------------------------------------------------------------
  always_comb begin
    mmu_req   = (state == XLATE);
    ram_en    = (state == ACCESS);
    // Decoded from state so an async reset during ACCESS drops the write
    // enable before the RAM can clock it.
    ram_we    = (state == ACCESS) & we_q;
    busy      = (state != IDLE);
    mmu_vaddr = addr_q;
    ram_addr  = paddr_q;
    ram_wdata = wdata_q;
  end

  // --------------------------------------------------------------------
  // Transaction context: latched on grant, updated through the access
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_FE;
      last_grant <= OWN_EX;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      paddr_q    <= '0;
      err_q      <= 1'b0;
      flushed    <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_owner;
            last_grant <= grant_owner;
            if (grant_owner == OWN_EX) begin
              addr_q  <= ex_addr;
              we_q    <= ex_we;
              wdata_q <= ex_wdata;
            end else begin
              addr_q  <= fe_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
            err_q   <= 1'b0;
            flushed <= 1'b0;
            cnt     <= '0;
          end
        end
        XLATE: begin
          if (xlate_ok) begin
            paddr_q <= mmu_paddr;
          end else if (xlate_fail) begin
            err_q <= 1'b1;
          end
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 4'd1;
          end
          if (owner == OWN_FE && fe_flush) begin
            flushed <= 1'b1;
          end
        end
        ACCESS: begin
          if (owner == OWN_FE && fe_flush) begin
            flushed <= 1'b1;
          end
        end
        RESP: begin
          flushed <= 1'b0;
        end
        default: begin
          flushed <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Response registers: ack/err pulse for one cycle after RESP
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fe_ack   <= 1'b0;
      fe_err   <= 1'b0;
      fe_rdata <= '0;
      ex_ack   <= 1'b0;
      ex_err   <= 1'b0;
      ex_rdata <= '0;
    end else begin
      fe_ack <= 1'b0;
      fe_err <= 1'b0;
      ex_ack <= 1'b0;
      ex_err <= 1'b0;
      if (state == RESP) begin
        if (owner == OWN_EX) begin
          ex_ack <= 1'b1;
          ex_err <= err_q;
          if (!we_q && !err_q) begin
            ex_rdata <= ram_dout;
          end
        end else if (!fe_suppress) begin
          fe_ack <= 1'b1;
          fe_err <= err_q;
          if (!err_q) begin
            fe_rdata <= ram_dout;
          end
        end
      end
    end
  end

endmodule
